apb_reg_slave_bridge: RTL and testbench
=======================================

# apb_reg_slave_bridge

Parametrised APB4 slave front-end between the peripheral APB bus and a register module. It supersedes the fixed 12-bit/32-bit single-cycle bridge with:
- configurable address/data width and register count;
- byte strobes;
- a configurable register read latency;
- PSLVERR generation for out-of-range or misaligned accesses.

Every accepted transfer becomes exactly one register-side strobe and one PREADY pulse.

## Interface
- ADDR_W, 12, APB address width (≥ 3)
- DATA_W, 32, data width; multiple of 8, ≥ 16
- NUM_REGS, 64, word registers implemented; power of two, ≤ 2^(ADDR_W-2)
- RD_LATENCY, 1, cycles from reg_re_o to valid reg_rdata_i; 0..3
- IDX_W (localparam) = clog2(NUM_REGS); STRB_W (localparam) = DATA_W/8
- apb_pclk_i  in  1  single clock; all logic on rising edge
- apb_presetn_i  in  1  asynchronous, active-low reset
- apb_paddr_i  in  ADDR_W  byte address
- apb_psel_i, apb_penable_i, apb_pwrite_i  in  1  APB controls
- apb_pwdata_i  in  DATA_W  write data
- apb_pstrb_i  in  STRB_W  write byte strobes
- apb_pready_o  out  1  transfer complete
- apb_prdata_o  out  DATA_W  registered read data
- apb_pslverr_o  out  1  error response, valid with pready
- reg_idx_o  out  IDX_W  word index, held stable from reg strobe through response
- reg_wdata_o  out  DATA_W  latched write data
- reg_be_o  out  STRB_W  latched strobes
- reg_we_o  out  1  one-cycle write strobe
- reg_re_o  out  1  one-cycle read strobe
- reg_rdata_i  in  DATA_W  register read data

## Operation
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - On psel & !penable (setup), latch paddr, pwrite, pwdata and pstrb.
  - Compute err = (paddr[1:0] != 0) | (paddr[ADDR_W-1:2] ≥ NUM_REGS).
  - Go to ACCESS.
  - penable without a preceding setup in IDLE is ignored.
- ACCESS:
  - If err, go to RESP with no register strobe.
  - Write: reg_we_o = 1 only if latched strobes ≠ 0; go to RESP. An all-zero-strobe write completes with no strobe and pslverr = 0.
  - Read, RD_LATENCY = 0: reg_re_o = 1; capture reg_rdata_i this cycle; go to RESP.
  - Read, RD_LATENCY > 0: reg_re_o = 1; load the latency counter with RD_LATENCY; go to RDWAIT.
- RDWAIT:
  - Decrement the counter each cycle.
  - When it reaches 1, capture reg_rdata_i into the prdata register and go to RESP.
- RESP:
  - pready_o = 1 for exactly one cycle; pslverr_o = err.
  - prdata_o = captured data for a good read; 0 for writes and errors.
  - Next state is IDLE.
- Abort: psel low in ACCESS or RDWAIT returns the FSM to IDLE.
  - No response is given; already-issued strobes are not retracted.
  - prdata is unchanged.
- Pipelined reads: pwrite, paddr and pstrb changes after setup are ignored; the latched values rule.
- Reset (apb_presetn_i low, any state): FSM to IDLE; counter 0. All outputs go to 0: pready, pslverr, prdata, reg_idx, reg_wdata, reg_be, reg_we, reg_re.

## Timing
- Setup sampled at edge E0.
- ACCESS during cycle E0→E1; the strobe is visible in this cycle.
- Write, or read with RD_LATENCY = 0: pready high in cycle E1→E2. Transfer ends at E2: one wait state, total 3 APB cycles.
- Read with RD_LATENCY = L > 0: pready high in cycle E(L+1)→E(L+2); L+1 wait states.
- Back-to-back: a new setup is accepted the cycle after RESP. Minimum transfer spacing is 3 cycles.
- prdata_o and pslverr_o are registered and change only on entry to RESP (or reset). No combinational path from reg_rdata_i to prdata_o.

## Structure
- Package apb_reg_slave_pkg holds:
  - the state enum (IDLE, ACCESS, RDWAIT, RESP);
  - the latency counter width constant (2 bits);
  - an alignment/range-check function parameterised by ADDR_W and NUM_REGS.
- Single module, no sub-modules. The latency counter is small enough to stay inline.

## Test plan
- Write 0xDEADBEEF, pstrb 0xF, to 0x010 -> reg_we_o pulses once with reg_idx_o = 4 and reg_be_o = 0xF; pready after 1 wait state; pslverr = 0.
- Read 0x020, RD_LATENCY = 2, reg_rdata_i = 0x12345678 -> reg_re_o pulses once with idx 8; pready after 3 wait states; prdata = 0x12345678.
- Read 0x102, misaligned -> no reg_re_o; pslverr = 1; prdata = 0.
- Write 0x100 with NUM_REGS = 64 (out of range) -> no reg_we_o; pslverr = 1.
- Write with pstrb = 0 -> no reg_we_o; pready after 1 wait state; pslverr = 0.
- Assert apb_presetn_i low during RDWAIT -> all outputs 0 immediately. The next setup after release completes normally.

Source files
------------

// File: rtl/apb_reg_slave_pkg.sv
// Shared types and helpers for the APB4 register slave bridge.
package apb_reg_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Wide enough to hold the largest read latency (3).
  localparam int CNT_W = 2;

  // True when a byte address is not word aligned or lands past the last register.
  // The caller zero-extends its ADDR_W-bit address; addr_w masks off anything above it.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input int          addr_w,
                                    input int          num_regs);
    logic [31:0] w_word;
    if (addr_w >= 32) w_word = addr >> 2;
    else              w_word = (addr & ((32'd1 << addr_w) - 32'd1)) >> 2;
    return (addr[1:0] != 2'b00) || (w_word >= 32'(num_regs));
  endfunction

endpackage

// File: rtl/apb_reg_slave_bridge.sv
// APB4 slave front-end: turns each accepted transfer into one register strobe
// and one PREADY pulse, with configurable read latency and PSLVERR on bad addresses.
module apb_reg_slave_bridge
  import apb_reg_slave_pkg::*;
#(
  parameter  int ADDR_W     = 12,
  parameter  int DATA_W     = 32,
  parameter  int NUM_REGS   = 64,
  parameter  int RD_LATENCY = 1,
  localparam int IDX_W      = $clog2(NUM_REGS),
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              apb_pclk_i,
  input  logic              apb_presetn_i,
  input  logic [ADDR_W-1:0] apb_paddr_i,
  input  logic              apb_psel_i,
  input  logic              apb_penable_i,
  input  logic              apb_pwrite_i,
  input  logic [DATA_W-1:0] apb_pwdata_i,
  input  logic [STRB_W-1:0] apb_pstrb_i,
  output logic              apb_pready_o,
  output logic [DATA_W-1:0] apb_prdata_o,
  output logic              apb_pslverr_o,
  output logic [IDX_W-1:0]  reg_idx_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [STRB_W-1:0] reg_be_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic              r_err;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_be;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pslverr;

  logic w_setup;
  logic w_good_rd;
  logic w_enter_resp;

  assign w_setup      = apb_psel_i && !apb_penable_i;
  assign w_good_rd    = !r_write && !r_err;
  assign w_enter_resp = (w_state_nxt == ST_RESP);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_setup) w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (!apb_psel_i)                                  w_state_nxt = ST_IDLE;
        else if (r_err || r_write || (RD_LATENCY == 0))   w_state_nxt = ST_RESP;
        else                                              w_state_nxt = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (!apb_psel_i)                 w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_W'(1))     w_state_nxt = ST_RESP;
      end
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == ST_IDLE && w_setup) begin
        r_write <= apb_pwrite_i;
        r_err   <= addr_err(32'(apb_paddr_i), ADDR_W, NUM_REGS);
        r_idx   <= apb_paddr_i[IDX_W+1:2];
        r_wdata <= apb_pwdata_i;
        r_be    <= apb_pstrb_i;
      end

      if (r_state == ST_ACCESS && w_state_nxt == ST_RDWAIT)
        r_cnt <= CNT_W'(RD_LATENCY);
      else if (r_state == ST_RDWAIT && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);

      // Response registers move only on the edge that enters RESP; aborts leave them alone.
      if (w_enter_resp) begin
        r_pslverr <= r_err;
        r_prdata  <= w_good_rd ? reg_rdata_i : '0;
      end
    end
  end

  assign apb_pready_o  = (r_state == ST_RESP);
  assign apb_prdata_o  = r_prdata;
  assign apb_pslverr_o = r_pslverr;
  assign reg_idx_o     = r_idx;
  assign reg_wdata_o   = r_wdata;
  assign reg_be_o      = r_be;
  assign reg_we_o      = (r_state == ST_ACCESS) && r_write && !r_err && (r_be != '0);
  assign reg_re_o      = (r_state == ST_ACCESS) && w_good_rd;

endmodule

// File: tb/tb_apb_reg_slave_bridge.sv
// Scoreboard bench for apb_reg_slave_bridge: a driver predicts each response from an
// address/register model, a negedge monitor pops and compares when PREADY appears.
module tb_apb_reg_slave_bridge;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 64;
  localparam int RD_LAT   = 2;
  localparam int IDX_W    = 6;
  localparam int STRB_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] paddr;
  logic              psel, penable, pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready, pslverr;
  logic [DATA_W-1:0] prdata;
  logic [IDX_W-1:0]  reg_idx;
  logic [DATA_W-1:0] reg_wdata;
  logic [STRB_W-1:0] reg_be;
  logic              reg_we, reg_re;
  logic [DATA_W-1:0] reg_rdata;

  always #5 clk = ~clk;

  apb_reg_slave_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RD_LATENCY(RD_LAT)
  ) dut (
    .apb_pclk_i(clk), .apb_presetn_i(rst_n),
    .apb_paddr_i(paddr), .apb_psel_i(psel), .apb_penable_i(penable),
    .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata), .apb_pstrb_i(pstrb),
    .apb_pready_o(pready), .apb_prdata_o(prdata), .apb_pslverr_o(pslverr),
    .reg_idx_o(reg_idx), .reg_wdata_o(reg_wdata), .reg_be_o(reg_be),
    .reg_we_o(reg_we), .reg_re_o(reg_re), .reg_rdata_i(reg_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          n_we;
    int          n_re;
    logic [5:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_err    = 0;
  int          we_cnt   = 0;
  int          re_cnt   = 0;
  logic [5:0]  s_idx;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [3:0]  re_hist;
  logic [31:0] last_prdata = '0;
  logic [31:0] regfile [NUM_REGS];
  logic [31:0] model   [NUM_REGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Reference: what the bus should see for a transfer, and its effect on the register model.
  task automatic predict(input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                         input logic [3:0] st, output exp_t e);
    int widx;
    widx    = int'(addr) / 4;
    e.err   = (int'(addr) % 4 != 0) || (widx >= NUM_REGS);
    e.idx   = 6'(widx % NUM_REGS);
    e.n_we  = (wr && !e.err && st != 4'd0) ? 1 : 0;
    e.n_re  = (!wr && !e.err) ? 1 : 0;
    e.wdata = wd;
    e.be    = st;
    e.rdata = (e.n_re == 1) ? model[widx] : 32'd0;
    if (e.n_we == 1) model[widx] = merge(model[widx], wd, st);
  endtask

  // Register-module stand-in plus response monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      re_hist = '0;
    end else begin
      if (reg_we) begin
        we_cnt++;
        s_idx   = reg_idx;
        s_wdata = reg_wdata;
        s_be    = reg_be;
        regfile[reg_idx] = merge(regfile[reg_idx], reg_wdata, reg_be);
      end
      if (reg_re) begin
        re_cnt++;
        s_idx = reg_idx;
      end
      // Read data is only valid exactly RD_LAT cycles after the read strobe.
      re_hist   = {re_hist[2:0], reg_re};
      reg_rdata = re_hist[RD_LAT] ? regfile[reg_idx] : $urandom;
      if (pready) begin
        if (exp_q.size() == 0) begin
          check("pready without transfer", {63'd0, pready}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pslverr", {63'd0, pslverr}, {63'd0, mon_e.err});
          check("prdata", prdata, mon_e.rdata);
          check("we strobe count", we_cnt, mon_e.n_we);
          check("re strobe count", re_cnt, mon_e.n_re);
          if (mon_e.n_we + mon_e.n_re > 0) check("strobe idx", s_idx, mon_e.idx);
          if (mon_e.n_we > 0) begin
            check("reg_wdata", s_wdata, mon_e.wdata);
            check("reg_be", s_be, mon_e.be);
          end
          if (!mon_e.err) check("idx held to resp", reg_idx, mon_e.idx);
          last_prdata = mon_e.rdata;
        end
        we_cnt = 0;
        re_cnt = 0;
      end
    end
  end

  task automatic setup_phase(input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                             input logic [3:0] st);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    // Latched values must rule; scramble the bus during the access phase.
    penable = 1'b1; paddr = 12'($urandom); pwrite = 1'($urandom);
    pwdata = $urandom; pstrb = 4'($urandom);
  endtask

  task automatic xfer(input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st);
    exp_t e;
    int   waits;
    predict(addr, wr, wd, st, e);
    exp_q.push_back(e);
    setup_phase(addr, wr, wd, st);
    waits = 0;
    while (waits < 16) begin
      @(negedge clk);
      if (pready) break;
      waits++;
    end
    check("wait states", waits, (e.err || wr) ? 1 : RD_LAT + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel    = 1'($urandom);
      penable = psel ? 1'b1 : 1'($urandom);
      pwrite  = 1'($urandom);
      paddr   = 12'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          kind;
    logic [11:0] a;
    logic [3:0]  st;
    bit          seen;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; reg_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regfile[i] = $urandom;
      model[i]   = regfile[i];
    end
    regfile[8] = 32'h1234_5678;
    model[8]   = 32'h1234_5678;

    repeat (3) @(posedge clk);
    #1;
    check("reset ctl", {pready, pslverr, reg_we, reg_re, reg_be, reg_idx}, 64'd0);
    check("reset prdata", prdata, 64'd0);
    check("reset wdata", reg_wdata, 64'd0);
    rst_n = 1'b1;

    // Directed cases, issued back-to-back at minimum spacing.
    xfer(12'h010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    xfer(12'h020, 1'b0, 32'h0, 4'h0);
    xfer(12'h102, 1'b0, 32'h0, 4'h0);
    xfer(12'h100, 1'b1, $urandom, 4'hF);
    xfer(12'h014, 1'b1, $urandom, 4'h0);
    xfer(12'h010, 1'b0, 32'h0, 4'h0);
    xfer(12'h014, 1'b0, 32'h0, 4'h0);
    idle(3);

    // Abort: drop psel while waiting for read data.
    setup_phase(12'h024, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready) seen = 1'b1;
    end
    check("abort no pready", {63'd0, seen}, 64'd0);
    check("abort re strobe", re_cnt, 1);
    check("abort prdata held", prdata, last_prdata);
    #1;
    we_cnt = 0; re_cnt = 0;

    // Reset in RDWAIT.
    setup_phase(12'h028, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rdwait reset ctl", {pready, pslverr, reg_we, reg_re, reg_be, reg_idx}, 64'd0);
    check("rdwait reset prdata", prdata, 64'd0);
    check("rdwait reset wdata", reg_wdata, 64'd0);
    exp_q.delete();
    we_cnt = 0; re_cnt = 0; last_prdata = '0;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(12'h020, 1'b0, 32'h0, 4'h0);
    xfer(12'h028, 1'b0, 32'h0, 4'h0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)       a = {4'b0, 6'($urandom_range(0, 63)), 2'b00};
      else if (kind == 7) a = {4'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else                a = 12'($urandom_range(64, 1023)) << 2;
      st = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      xfer(a, 1'($urandom), $urandom, st);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
